// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Holds the controller state encoding and the operation-select values.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_full_add_cell.sv
// Single-bit full adder: sum is the parity of the inputs, carry is the majority.
// The serial datapath reuses this one cell for every bit position.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
// Subtraction is done as X + ~Y + 1 by inverting Y at load and seeding the carry.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-2:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_v;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_sub;

  assign w_last = (r_cnt == LAST_BIT);
  assign w_sub  = (mode == MODE_SUB);

  full_add_cell u_cell (
    .a    (r_x[0]),
    .b    (r_y[0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= X;
            r_y     <= Y ^ {WIDTH{w_sub}};
            r_carry <= w_sub;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_x     <= r_x >> 1;
          r_y     <= r_y >> 1;
          r_acc   <= (WIDTH-1)'({w_sum, r_acc} >> 1);
          r_carry <= w_cout;
          if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            // Final bit: r_carry is the carry into the MSB, w_cout the carry out of it.
            r_s    <= {w_sum, r_acc};
            r_cout <= w_cout;
            r_v    <= r_carry ^ w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;
  assign V    = r_v;

endmodule
